bloom_lut_ctrl: RTL and testbench
=================================

Name: bloom_lut_ctrl

Overview:
Programming controller for the per-hash bloom LUTs read by the string-size bloom engines. It accepts host commands (clear all LUTs, set bit, clear bit) and drives the LUT write ports. Before any write it quiesces the engines by dropping their enable and waiting for their pipelines to drain, so no lookup ever sees a half-updated filter. It sits between the host configuration port and the LUT memories, beside the engines' read masters.

Parameters:
HASHES_CNT, 6, number of hash LUTs (one per hash function)
HASH_W, 12, LUT address width; each LUT is 2**HASH_W x 1 bit

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous active-high reset
cmd_op_i  in  2  0=CLEAR_ALL, 1=SET_BIT, 2=CLR_BIT, 3=reserved
cmd_lut_sel_i  in  HASHES_CNT  bit i selects LUT i
cmd_addr_i  in  HASH_W  bit address (ignored for CLEAR_ALL)
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_err_o  out  1  one-cycle pulse: reserved op accepted and dropped
lut_write_o  out  HASHES_CNT  per-LUT write strobe
lut_address_o  out  HASHES_CNT*HASH_W  per-LUT write address
lut_writedata_o  out  HASHES_CNT  per-LUT write bit
engine_enable_o  out  1  engines may accept new strings
engine_busy_i  in  1  OR of all engines' in-flight valids
lut_ready_o  out  1  every LUT cleared at least once since reset
busy_o  out  1  controller not in IDLE

Behaviour:
- Reset values: state IDLE; cleared mask 0; all outputs 0 (cmd_ready_o rises the cycle after srst_i falls).
- States: IDLE, DRAIN, CLEAR, WRITE. All outputs except cmd_ready_o are registered.
- IDLE: cmd_ready_o=1. On accept of op 0/1/2: latch op, sel, addr; go to DRAIN. On accept of op 3: pulse cmd_err_o next cycle, stay IDLE, engine_enable_o unaffected.
- engine_enable_o = 1 only in IDLE with lut_ready_o=1. It is low from the cycle after a command is accepted.
- DRAIN: cmd_ready_o=0. Stay at least 1 cycle, then until engine_busy_i=0 is sampled. Then go to CLEAR for op 0, or to WRITE for ops 1/2. The extra cycle covers the string accepted in the command-accept cycle.
- WRITE (1 cycle):
  - lut_write_o = latched sel.
  - All lut_address_o lanes = latched addr.
  - lut_writedata_o = all ones for SET_BIT, all zeros for CLR_BIT.
  - Next state IDLE.
- CLEAR:
  - HASH_W-bit counter starts at 0 and increments every cycle.
  - lut_write_o = sel, writedata 0, every lane address = counter.
  - Exactly 2**HASH_W write cycles; leave after address all-ones.
  - On exit, cleared mask |= sel; go to IDLE.
- Latency with engine_busy_i=0: SET/CLR accepted at T -> DRAIN at T+1 -> write at T+2 -> IDLE, cmd_ready_o=1 at T+3. CLEAR_ALL accepted at T -> writes T+2 .. T+1+2**HASH_W.
- lut_write_o is 0 in every state except WRITE/CLEAR. Address and writedata are don't-care when their strobe is 0; the bench checks them only under strobe.
- sel = 0: full sequence still runs (drain, timing), with no strobes asserted and no change to the cleared mask.
- SET/CLR issued before lut_ready_o: executed normally; engines stay disabled until all LUTs are cleared.
- busy_o = (state != IDLE).
- Back-to-back commands: the next command is accepted on the first IDLE cycle. engine_enable_o goes high for that cycle only, then drops again.
- srst_i mid-operation (including mid-CLEAR): immediate return to reset values. The cleared mask is lost, so the host must reissue CLEAR_ALL.

Test Plan:
- Reset, then CLEAR_ALL sel=6'h3F with engine_busy_i=0 -> 4096 cycles of strobe 6'h3F, addresses 0..4095 in order, data 0. lut_ready_o and engine_enable_o rise the cycle after the last write.
- SET_BIT sel=6'b000101, addr=12'hABC after init -> single write cycle at T+2: strobes lanes 0 and 2, address 0xABC, data 1. cmd_ready_o low T+1..T+2, high at T+3.
- SET_BIT with engine_busy_i held high 5 cycles after accept -> controller stays in DRAIN, no write until the first cycle after busy falls. engine_enable_o low throughout.
- op=3 in IDLE -> accepted in 1 cycle, cmd_err_o pulses once, no strobes, engine_enable_o stays 1.
- CLEAR_ALL sel=6'h0F only -> lut_ready_o stays 0 and engine_enable_o stays 0. A following CLEAR_ALL sel=6'h30 -> both go to 1.
- srst_i asserted at counter=100 during CLEAR -> next cycle all strobes 0, lut_ready_o=0, state IDLE, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/bloom_lut_ctrl.sv
// Bloom LUT programming controller: takes host clear/set/clear-bit commands,
// drains the lookup engines, then drives the per-hash LUT write ports.
module bloom_lut_ctrl #(
    parameter int unsigned HASHES_CNT = 6,
    parameter int unsigned HASH_W     = 12
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic [1:0]                   cmd_op_i,
    input  logic [HASHES_CNT-1:0]        cmd_lut_sel_i,
    input  logic [HASH_W-1:0]            cmd_addr_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    output logic                         cmd_err_o,
    output logic [HASHES_CNT-1:0]        lut_write_o,
    output logic [HASHES_CNT*HASH_W-1:0] lut_address_o,
    output logic [HASHES_CNT-1:0]        lut_writedata_o,
    output logic                         engine_enable_o,
    input  logic                         engine_busy_i,
    output logic                         lut_ready_o,
    output logic                         busy_o
);

    localparam int unsigned LANES_W = HASHES_CNT * HASH_W;

    localparam logic [1:0] OP_CLEAR_ALL = 2'd0;
    localparam logic [1:0] OP_SET_BIT   = 2'd1;
    localparam logic [1:0] OP_RSVD      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR,
        ST_WRITE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [HASHES_CNT-1:0]  sel_q, sel_d;
    logic [HASH_W-1:0]      addr_q, addr_d;
    logic [HASH_W-1:0]      cnt_q, cnt_d;
    logic [HASHES_CNT-1:0]  mask_q, mask_d;
    logic                   rdy_en_q;

    logic                   err_q, err_d;
    logic [HASHES_CNT-1:0]  wr_q, wr_d;
    logic [LANES_W-1:0]     la_q, la_d;
    logic [HASHES_CNT-1:0]  wd_q, wd_d;
    logic                   en_q, en_d;
    logic                   lrdy_q, lrdy_d;
    logic                   busy_q, busy_d;

    logic                   accept;

    // Ready is held low for the first cycle out of reset.
    assign cmd_ready_o = rdy_en_q && (state_q == ST_IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

    assign cmd_err_o       = err_q;
    assign lut_write_o     = wr_q;
    assign lut_address_o   = la_q;
    assign lut_writedata_o = wd_q;
    assign engine_enable_o = en_q;
    assign lut_ready_o     = lrdy_q;
    assign busy_o          = busy_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            sel_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            rdy_en_q <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= '0;
            la_q     <= '0;
            wd_q     <= '0;
            en_q     <= 1'b0;
            lrdy_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            rdy_en_q <= 1'b1;
            err_q    <= err_d;
            wr_q     <= wr_d;
            la_q     <= la_d;
            wd_q     <= wd_d;
            en_q     <= en_d;
            lrdy_q   <= lrdy_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op_i == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = cmd_op_i;
                        sel_d   = cmd_lut_sel_i;
                        addr_d  = cmd_addr_i;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!engine_busy_i) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_CLEAR_ALL) ? ST_CLEAR : ST_WRITE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + HASH_W'(1);
                if (&cnt_q) begin
                    mask_d  = mask_q | sel_q;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_d   = '0;
        wd_d   = '0;
        la_d   = {HASHES_CNT{addr_q}};
        if (state_d == ST_CLEAR) begin
            wr_d = sel_q;
            la_d = {HASHES_CNT{cnt_d}};
        end else if (state_d == ST_WRITE) begin
            wr_d = sel_q;
            wd_d = (op_q == OP_SET_BIT) ? '1 : '0;
        end
        lrdy_d = &mask_d;
        en_d   = (state_d == ST_IDLE) && (&mask_d);
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_bloom_lut_ctrl.sv
// Self-checking bench for bloom_lut_ctrl: command table plus clear/drain/reset sequences,
// with a write scoreboard checked on every strobe.
module tb_bloom_lut_ctrl;

    localparam int unsigned H   = 6;
    localparam int unsigned W   = 12;
    localparam int unsigned LUT = 1 << W;

    logic           clk = 1'b0;
    logic           srst_i = 1'b1;
    logic [1:0]     cmd_op_i = '0;
    logic [H-1:0]   cmd_lut_sel_i = '0;
    logic [W-1:0]   cmd_addr_i = '0;
    logic           cmd_valid_i = 1'b0;
    logic           cmd_ready_o;
    logic           cmd_err_o;
    logic [H-1:0]   lut_write_o;
    logic [H*W-1:0] lut_address_o;
    logic [H-1:0]   lut_writedata_o;
    logic           engine_enable_o;
    logic           engine_busy_i = 1'b0;
    logic           lut_ready_o;
    logic           busy_o;

    bloom_lut_ctrl #(.HASHES_CNT(H), .HASH_W(W)) dut (
        .clk_i           (clk),
        .srst_i          (srst_i),
        .cmd_op_i        (cmd_op_i),
        .cmd_lut_sel_i   (cmd_lut_sel_i),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_err_o       (cmd_err_o),
        .lut_write_o     (lut_write_o),
        .lut_address_o   (lut_address_o),
        .lut_writedata_o (lut_writedata_o),
        .engine_enable_o (engine_enable_o),
        .engine_busy_i   (engine_busy_i),
        .lut_ready_o     (lut_ready_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int           cyc;
        logic [H-1:0] sel;
        logic [W-1:0] addr;
        logic [H-1:0] data;
    } wr_t;

    wr_t sb[$];

    typedef struct {
        logic [1:0]   op;
        logic [H-1:0] sel;
        logic [W-1:0] addr;
        logic         exp_err;
        logic [H-1:0] exp_wr;
        logic [H-1:0] exp_data;
    } vec_t;

    logic [H-1:0] model_mask = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t            e;
        logic [H*W-1:0] m;
        if (lut_write_o != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 128'(lut_write_o), 128'(0));
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < H; i++) m[i*W +: W] = {W{e.sel[i]}};
                chk("wr_cycle", 128'(cyc), 128'(e.cyc));
                chk("wr_strobe", 128'(lut_write_o), 128'(e.sel));
                chk("wr_addr", 128'(lut_address_o & m), 128'({H{e.addr}} & m));
                chk("wr_data", 128'(lut_writedata_o & e.sel), 128'(e.data & e.sel));
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("missed_write", 128'(lut_write_o), 128'(e.sel));
        end
    end

    task automatic send(input logic [1:0] op, input logic [H-1:0] sel,
                        input logic [W-1:0] addr, output int t);
        int guard = 0;
        cmd_op_i      = op;
        cmd_lut_sel_i = sel;
        cmd_addr_i    = addr;
        cmd_valid_i   = 1'b1;
        while (!cmd_ready_o && guard < 100) begin
            step();
            guard++;
        end
        if (!cmd_ready_o) chk("accept_timeout", 128'(cmd_ready_o), 128'(1));
        t = cyc;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        srst_i      = 1'b1;
        cmd_valid_i = 1'b0;
        engine_busy_i = 1'b0;
        repeat (3) step();
        chk("rst_ready", 128'(cmd_ready_o), 128'(0));
        chk("rst_outs", 128'({cmd_err_o, lut_write_o, lut_writedata_o, engine_enable_o, lut_ready_o, busy_o}), 128'(0));
        srst_i = 1'b0;
        model_mask = '0;
        chk("rel_ready_low", 128'(cmd_ready_o), 128'(0));
        step();
        chk("rel_ready_high", 128'(cmd_ready_o), 128'(1));
    endtask

    task automatic do_clear(input logic [H-1:0] sel);
        int t;
        logic old_ready;
        old_ready = &model_mask;
        send(2'd0, sel, '0, t);
        for (int i = 0; i < int'(LUT); i++) begin
            wr_t e;
            e.cyc = t + 2 + i; e.sel = sel; e.addr = W'(i); e.data = '0;
            if (sel != '0) sb.push_back(e);
        end
        chk("clr_enable_low", 128'(engine_enable_o), 128'(0));
        while (cyc < t + 1 + int'(LUT)) step();
        chk("clr_last_busy", 128'(busy_o), 128'(1));
        chk("clr_last_ready", 128'(lut_ready_o), 128'(old_ready));
        step();
        model_mask = model_mask | sel;
        chk("clr_done_busy", 128'(busy_o), 128'(0));
        chk("clr_done_cmd_ready", 128'(cmd_ready_o), 128'(1));
        chk("clr_done_lut_ready", 128'(lut_ready_o), 128'(&model_mask));
        chk("clr_done_enable", 128'(engine_enable_o), 128'(&model_mask));
    endtask

    task automatic run_vec(input vec_t v);
        int  t;
        wr_t e;
        send(v.op, v.sel, v.addr, t);
        if (v.exp_wr != '0) begin
            e.cyc = t + 2; e.sel = v.exp_wr; e.addr = v.addr; e.data = v.exp_data;
            sb.push_back(e);
        end
        chk("t1_err", 128'(cmd_err_o), 128'(v.exp_err));
        chk("t1_busy", 128'(busy_o), 128'(!v.exp_err));
        chk("t1_cmd_ready", 128'(cmd_ready_o), 128'(v.exp_err));
        chk("t1_enable", 128'(engine_enable_o), 128'(v.exp_err && (&model_mask)));
        if (!v.exp_err) begin
            step();
            chk("t2_cmd_ready", 128'(cmd_ready_o), 128'(0));
            chk("t2_busy", 128'(busy_o), 128'(1));
            step();
            chk("t3_cmd_ready", 128'(cmd_ready_o), 128'(1));
            chk("t3_busy", 128'(busy_o), 128'(0));
            chk("t3_err", 128'(cmd_err_o), 128'(0));
            chk("t3_enable", 128'(engine_enable_o), 128'(&model_mask));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t pre;
        int   t;

        vecs[0] = '{2'd1, 6'b000101, 12'hABC, 1'b0, 6'b000101, 6'h3F};
        vecs[1] = '{2'd2, 6'b000101, 12'hABC, 1'b0, 6'b000101, 6'h00};
        vecs[2] = '{2'd3, 6'h3F,     12'h123, 1'b1, 6'h00,     6'h00};
        vecs[3] = '{2'd1, 6'h3F,     12'h000, 1'b0, 6'h3F,     6'h3F};
        vecs[4] = '{2'd1, 6'h3F,     12'hFFF, 1'b0, 6'h3F,     6'h3F};
        vecs[5] = '{2'd2, 6'b100010, 12'h123, 1'b0, 6'b100010, 6'h00};
        vecs[6] = '{2'd1, 6'h00,     12'h456, 1'b0, 6'h00,     6'h00};
        pre     = '{2'd1, 6'b000010, 12'h010, 1'b0, 6'b000010, 6'h3F};

        do_reset();
        do_clear(6'h3F);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Drain holds while the engines report in-flight work.
        begin
            wr_t e;
            send(2'd1, 6'b000001, 12'h555, t);
            e.cyc = t + 7; e.sel = 6'b000001; e.addr = 12'h555; e.data = 6'h3F;
            sb.push_back(e);
            engine_busy_i = 1'b1;
            for (int k = 0; k < 5; k++) begin
                chk("drain_enable", 128'(engine_enable_o), 128'(0));
                chk("drain_busy", 128'(busy_o), 128'(1));
                step();
            end
            engine_busy_i = 1'b0;
            chk("drain_still_busy", 128'(busy_o), 128'(1));
            step();
            step();
            chk("drain_done_busy", 128'(busy_o), 128'(0));
            chk("drain_done_enable", 128'(engine_enable_o), 128'(1));
        end

        // Partial clears: ready only once every LUT has been cleared.
        do_reset();
        do_clear(6'h0F);
        do_clear(6'h30);

        // Reset in the middle of a clear drops everything.
        begin
            send(2'd0, 6'h3F, '0, t);
            for (int i = 0; i <= 100; i++) begin
                wr_t e;
                e.cyc = t + 2 + i; e.sel = 6'h3F; e.addr = W'(i); e.data = '0;
                sb.push_back(e);
            end
            while (cyc < t + 102) step();
            srst_i = 1'b1;
            step();
            chk("midrst_strobe", 128'(lut_write_o), 128'(0));
            chk("midrst_lut_ready", 128'(lut_ready_o), 128'(0));
            chk("midrst_busy", 128'(busy_o), 128'(0));
            chk("midrst_enable", 128'(engine_enable_o), 128'(0));
            srst_i = 1'b0;
            model_mask = '0;
            step();
            chk("midrst_cmd_ready", 128'(cmd_ready_o), 128'(1));
        end

        // A bit write before any clear still executes; engines stay off.
        run_vec(pre);

        repeat (3) step();
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
